sam_enc_param: RTL and testbench

Parametrised next-generation SAM serial encoder. Receives a serial configuration (length exponent n, key d, key K) on `str` while `mode`=1. It then decodes pulse-width-modulated message bits on `str` while `mode`=0 and emits the encoded word msgcd[i] = (bit[i] ^ d[i]) | K[i], with a one-cycle valid strobe. Compared with the previous generation it adds:
- message length scalable by parameter,
- programmable symbol-width limits,
- configuration error reporting,
- continuous back-to-back messages without reconfiguration.

---
 rtl/sam_enc_param.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sam_enc_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sam_enc_param.sv
// Parametrised SAM serial encoder: serial key configuration, PWM symbol decode, keyed encode.
// Optional illegal-symbol counter output drop_cnt is built when SAM_ENC_DROPCNT_EN is defined.
module sam_enc_param #(
   parameter int MAX_LOG2 = 4,
   parameter int N_W      = 4,
   parameter int CNT_W    = 6,
   parameter int MIN_SYM  = 10,
   parameter int MAX_SYM  = 60
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      str,
   input  logic                      mode,
   output logic [(2**MAX_LOG2)-1:0]  msgcd,
   output logic                      valid,
   output logic [MAX_LOG2:0]         cc,
   output logic                      busy,
   output logic                      cfg_err
`ifdef SAM_ENC_DROPCNT_EN
   ,
   output logic [7:0]                drop_cnt
`endif
);

   localparam int MAX_LEN = 2**MAX_LOG2;
   localparam int LEN_W   = MAX_LOG2 + 1;
   localparam int IDX_W   = MAX_LOG2;
   localparam int CFG_MAX = (N_W > MAX_LEN) ? N_W : MAX_LEN;
   localparam int CFG_W   = $clog2(CFG_MAX);
   localparam int SUM_W   = CNT_W + 1;

   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [N_W-1:0]   N_LIMIT = N_W'(MAX_LOG2);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CFG_N = 3'd1;
   localparam logic [2:0] S_CFG_D = 3'd2;
   localparam logic [2:0] S_CFG_K = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_RUN   = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [N_W-1:0]     n_q, n_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CFG_W-1:0]   cfg_cnt_q, cfg_cnt_d;
   logic [MAX_LEN-1:0] d_q, d_d;
   logic [MAX_LEN-1:0] k_q, k_d;
   logic [CNT_W-1:0]   ones_q, ones_d;
   logic [CNT_W-1:0]   zeros_q, zeros_d;
   logic               seen_low_q, seen_low_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [MAX_LEN-1:0] msgcd_q, msgcd_d;
   logic               valid_q, valid_d;
   logic [LEN_W-1:0]   cc_q, cc_d;
   logic               cfg_err_q, cfg_err_d;

   logic [SUM_W-1:0]   sym_sum;
   logic               sym_legal;
   logic               sym_bit;
   logic [N_W-1:0]     n_shift;
   logic [LEN_W-1:0]   n_len;
   logic [CFG_W-1:0]   cfg_last;
   logic               sym_edge;

   assign sym_sum   = {1'b0, ones_q} + {1'b0, zeros_q};
   assign sym_legal = (sym_sum >= SUM_W'(MIN_SYM)) && (sym_sum <= SUM_W'(MAX_SYM)) &&
                      (ones_q != '0) && (zeros_q != '0);
   assign sym_bit   = (ones_q >= zeros_q);
   assign n_shift   = {n_q[N_W-2:0], str};
   assign n_len     = LEN_W'(1) << n_shift;
   assign cfg_last  = CFG_W'(len_q - LEN_W'(1));
   // A symbol closes on the first high sample after its low phase.
   assign sym_edge  = str && seen_low_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      len_d      = len_q;
      cfg_cnt_d  = cfg_cnt_q;
      d_d        = d_q;
      k_d        = k_q;
      ones_d     = ones_q;
      zeros_d    = zeros_q;
      seen_low_d = seen_low_q;
      idx_d      = idx_q;
      msgcd_d    = msgcd_q;
      valid_d    = 1'b0;
      cc_d       = cc_q;
      cfg_err_d  = cfg_err_q;

      case (state_q)
         S_IDLE: begin
            n_d        = '0;
            len_d      = '0;
            cfg_cnt_d  = '0;
            d_d        = '0;
            k_d        = '0;
            ones_d     = '0;
            zeros_d    = '0;
            seen_low_d = 1'b0;
            idx_d      = '0;
            if (mode) begin
               state_d   = S_CFG_N;
               cfg_err_d = 1'b0;
               msgcd_d   = '0;
            end
         end

         S_CFG_N: begin
            if (!mode) begin
               state_d = S_IDLE;
            end else begin
               n_d       = n_shift;
               cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
               if (cfg_cnt_q == CFG_W'(N_W - 1)) begin
                  cfg_cnt_d = '0;
                  if (n_shift > N_LIMIT) begin
                     cfg_err_d = 1'b1;
                     state_d   = S_IDLE;
                  end else begin
                     len_d   = n_len;
                     state_d = S_CFG_D;
                  end
               end
            end
         end

         S_CFG_D: begin
            if (!mode) begin
               state_d = S_IDLE;
            end else begin
               d_d       = {d_q[MAX_LEN-2:0], str};
               cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
               if (cfg_cnt_q == cfg_last) begin
                  cfg_cnt_d = '0;
                  state_d   = S_CFG_K;
               end
            end
         end

         S_CFG_K: begin
            if (!mode) begin
               state_d = S_IDLE;
            end else begin
               k_d       = {k_q[MAX_LEN-2:0], str};
               cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
               if (cfg_cnt_q == cfg_last) begin
                  cfg_cnt_d = '0;
                  cc_d      = len_q;
                  state_d   = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (!mode) begin
               state_d    = S_RUN;
               idx_d      = IDX_W'(len_q - LEN_W'(1));
               ones_d     = '0;
               zeros_d    = '0;
               seen_low_d = 1'b0;
            end
         end

         S_RUN: begin
            if (mode) begin
               // Reconfiguration wins over any symbol closing this cycle.
               state_d    = S_CFG_N;
               msgcd_d    = '0;
               cfg_err_d  = 1'b0;
               n_d        = '0;
               len_d      = '0;
               d_d        = '0;
               k_d        = '0;
               cfg_cnt_d  = '0;
               ones_d     = '0;
               zeros_d    = '0;
               seen_low_d = 1'b0;
               idx_d      = '0;
            end else if (sym_edge) begin
               ones_d     = CNT_W'(1);
               zeros_d    = '0;
               seen_low_d = 1'b0;
               if (sym_legal) begin
                  msgcd_d[idx_q] = (sym_bit ^ d_q[idx_q]) | k_q[idx_q];
                  if (idx_q == '0) begin
                     valid_d = 1'b1;
                     idx_d   = IDX_W'(len_q - LEN_W'(1));
                  end else begin
                     idx_d = idx_q - IDX_W'(1);
                  end
               end
            end else if (str) begin
               ones_d = (ones_q == CNT_SAT) ? ones_q : ones_q + CNT_W'(1);
            end else begin
               seen_low_d = 1'b1;
               zeros_d    = (zeros_q == CNT_SAT) ? zeros_q : zeros_q + CNT_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         len_q      <= '0;
         cfg_cnt_q  <= '0;
         d_q        <= '0;
         k_q        <= '0;
         ones_q     <= '0;
         zeros_q    <= '0;
         seen_low_q <= 1'b0;
         idx_q      <= '0;
         msgcd_q    <= '0;
         valid_q    <= 1'b0;
         cc_q       <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         len_q      <= len_d;
         cfg_cnt_q  <= cfg_cnt_d;
         d_q        <= d_d;
         k_q        <= k_d;
         ones_q     <= ones_d;
         zeros_q    <= zeros_d;
         seen_low_q <= seen_low_d;
         idx_q      <= idx_d;
         msgcd_q    <= msgcd_d;
         valid_q    <= valid_d;
         cc_q       <= cc_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

`ifdef SAM_ENC_DROPCNT_EN
   logic [7:0] drop_q, drop_d;
   logic       drop_evt;
   logic       cfg_enter;

   assign drop_evt  = (state_q == S_RUN) && !mode && sym_edge && !sym_legal;
   assign cfg_enter = (state_q != S_CFG_N) && (state_d == S_CFG_N);

   always_comb begin
      drop_d = drop_q;
      if (cfg_enter) begin
         drop_d = '0;
      end else if (drop_evt && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`endif

   assign msgcd   = msgcd_q;
   assign valid   = valid_q;
   assign cc      = cc_q;
   assign cfg_err = cfg_err_q;
   assign busy    = (state_q == S_CFG_N) || (state_q == S_CFG_D) ||
                    (state_q == S_CFG_K) || (state_q == S_RUN);

endmodule

// File: tb/tb_sam_enc_param.sv
// Directed bench for sam_enc_param: configuration, PWM encode, glitch drop, back-to-back,
// configuration error, aborts, reset mid-message and maximum length.
module tb_sam_enc_param;

   localparam int MAX_LOG2 = 4;
   localparam int MAX_LEN  = 16;

   logic                clk;
   logic                reset;
   logic                str;
   logic                mode;
   logic [MAX_LEN-1:0]  msgcd;
   logic                valid;
   logic [MAX_LOG2:0]   cc;
   logic                busy;
   logic                cfg_err;
`ifdef SAM_ENC_DROPCNT_EN
   logic [7:0]          drop_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int v_mark   = 0;

   logic [MAX_LEN-1:0] exp_q[$];
   logic [MAX_LOG2:0]  exp_cc;

   sam_enc_param dut (
      .clk     (clk),
      .reset   (reset),
      .str     (str),
      .mode    (mode),
      .msgcd   (msgcd),
      .valid   (valid),
      .cc      (cc),
      .busy    (busy),
      .cfg_err (cfg_err)
`ifdef SAM_ENC_DROPCNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; outputs sampled 1 ns after the edge, valid strobes scoreboarded.
   task automatic drive(input logic s, input logic m);
      logic [MAX_LEN-1:0] e;
      str  = s;
      mode = m;
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("msgcd_at_valid", 32'(msgcd), 32'(e));
            check("cc_at_valid", 32'(cc), 32'(exp_cc));
         end
      end
   endtask

   task automatic sym(input int hi, input int lo);
      repeat (hi) drive(1'b1, 1'b0);
      repeat (lo) drive(1'b0, 1'b0);
   endtask

   task automatic send_bit(input logic b);
      if (b) sym(8, 4);
      else   sym(4, 8);
   endtask

   task automatic send_word(input logic [15:0] w, input int len);
      for (int i = len - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   // Enters CFG_N from IDLE or RUN, then shifts n, d and K; ends in WAIT.
   task automatic cfg(input logic [3:0] n, input int len, input logic [15:0] d, input logic [15:0] k);
      drive(1'b0, 1'b1);
      for (int i = 3; i >= 0; i--) drive(n[i], 1'b1);
      for (int i = len - 1; i >= 0; i--) drive(d[i], 1'b1);
      for (int i = len - 1; i >= 0; i--) drive(k[i], 1'b1);
   endtask

   initial begin
      reset  = 1'b1;
      str    = 1'b0;
      mode   = 1'b0;
      exp_cc = '0;

      // Reset state
      repeat (3) drive(1'b0, 1'b0);
      check("rst_msgcd", 32'(msgcd), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_cc", 32'(cc), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cfg_err", 32'(cfg_err), 32'h0);
`ifdef SAM_ENC_DROPCNT_EN
      check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
      reset = 1'b0;
      drive(1'b0, 1'b0);
      check("idle_busy", 32'(busy), 32'h0);

      // Basic encode: L=4, d=1010, K=0001, data 1100 -> 0111
      cfg(4'b0010, 4, 16'h000A, 16'h0001);
      check("wait_busy", 32'(busy), 32'h0);
      check("wait_cc", 32'(cc), 32'h4);
      drive(1'b1, 1'b0);
      check("run_busy", 32'(busy), 32'h1);
      exp_cc = 5'd4;
      exp_q.push_back(16'h0007);
      v_mark = n_valid;
      send_word(16'h000C, 4);
      check("basic_no_early_valid", 32'(n_valid - v_mark), 32'd0);
      drive(1'b1, 1'b0);
      check("basic_valid_count", 32'(n_valid - v_mark), 32'd1);
      drive(1'b1, 1'b0);
      check("valid_one_cycle", 32'(valid), 32'h0);
      check("msgcd_held", 32'(msgcd), 32'h0007);

      // Glitch rejection: 2H+3L symbol before bit 2 is dropped
      cfg(4'b0010, 4, 16'h000A, 16'h0001);
      check("msgcd_cleared_on_cfg", 32'(msgcd), 32'h0);
      drive(1'b1, 1'b0);
      exp_q.push_back(16'h0007);
      v_mark = n_valid;
      send_bit(1'b1);
      sym(2, 3);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      drive(1'b1, 1'b0);
      check("glitch_valid_count", 32'(n_valid - v_mark), 32'd1);
`ifdef SAM_ENC_DROPCNT_EN
      check("glitch_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

      // Back-to-back: 1111 -> 0101, 0000 -> 1011, same keys
      exp_q.push_back(16'h0005);
      exp_q.push_back(16'h000B);
      v_mark = n_valid;
      send_word(16'h000F, 4);
      send_word(16'h0000, 4);
      drive(1'b1, 1'b0);
      check("b2b_valid_count", 32'(n_valid - v_mark), 32'd2);

      // Configuration error: n=5 exceeds MAX_LOG2
      v_mark = n_valid;
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      check("cfg_err_set", 32'(cfg_err), 32'h1);
      check("cfg_err_busy", 32'(busy), 32'h0);
      repeat (3) drive(1'b0, 1'b0);
      check("cfg_err_sticky", 32'(cfg_err), 32'h1);
      check("cc_kept_after_err", 32'(cc), 32'h4);
      check("msgcd_after_err", 32'(msgcd), 32'h0);
`ifdef SAM_ENC_DROPCNT_EN
      check("drop_cnt_cleared", 32'(drop_cnt), 32'd0);
`endif
      drive(1'b0, 1'b1);
      check("cfg_err_cleared", 32'(cfg_err), 32'h0);
      check("cfg_n_busy", 32'(busy), 32'h1);

      // Abort in the middle of CFG_D
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      check("cfg_d_busy", 32'(busy), 32'h1);
      drive(1'b1, 1'b0);
      check("abort_busy", 32'(busy), 32'h0);
      check("cc_kept_after_abort", 32'(cc), 32'h4);
      repeat (2) drive(1'b1, 1'b0);
      check("err_abort_no_valid", 32'(n_valid - v_mark), 32'd0);

      // Reset after 2 of 4 RUN bits
      cfg(4'b0010, 4, 16'h000A, 16'h0001);
      drive(1'b1, 1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      drive(1'b1, 1'b0);
      check("msgcd_partial", 32'(msgcd), 32'h0004);
      repeat (3) drive(1'b1, 1'b0);
      v_mark = n_valid;
      reset = 1'b1;
      drive(1'b1, 1'b0);
      check("mid_rst_msgcd", 32'(msgcd), 32'h0);
      check("mid_rst_valid", 32'(valid), 32'h0);
      check("mid_rst_cc", 32'(cc), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_cfg_err", 32'(cfg_err), 32'h0);
      reset = 1'b0;
      send_bit(1'b0);
      send_bit(1'b0);
      drive(1'b1, 1'b0);
      check("mid_rst_no_valid", 32'(n_valid - v_mark), 32'd0);
      check("mid_rst_idle_busy", 32'(busy), 32'h0);

      // Maximum length: L=16, d=FFFF, K=0, data A5A5 -> 5A5A
      cfg(4'b0100, 16, 16'hFFFF, 16'h0000);
      check("max_cc", 32'(cc), 32'h10);
      drive(1'b1, 1'b0);
      exp_cc = 5'd16;
      exp_q.push_back(16'h5A5A);
      v_mark = n_valid;
      send_word(16'hA5A5, 16);
      drive(1'b1, 1'b0);
      check("max_valid_count", 32'(n_valid - v_mark), 32'd1);
      drive(1'b1, 1'b0);

      // Final report
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
